axis_pipeline_fifo_rx: RTL and testbench
========================================

Name: axis_pipeline_fifo_rx

Overview:
- Receive-end termination for a long AXI-Stream link in which both tvalid/tdata and tready are registered over LENGTH stages.
- Accepts beats from upstream, carries them through LENGTH forward register stages, and lands them in a local FIFO that absorbs every in-flight beat.
- Sends a pipelined (registered) tready back upstream, so no combinational path crosses the link in either direction.
- Sits at the consumer side of long floorplan routes in the stream fabric.

Parameters:
- DATA_WIDTH, 8, tdata width in bits
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep
- KEEP_WIDTH, (DATA_WIDTH/8), tkeep width
- LAST_ENABLE, 1, propagate tlast
- USER_ENABLE, 1, propagate tuser
- USER_WIDTH, 1, tuser width
- LENGTH, 2, register stages per direction; 0 = pure bypass
- FIFO_DEPTH, 4*LENGTH, output FIFO entries; power of two, >= 2*LENGTH+2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  DATA_WIDTH  input data
- s_axis_tkeep  in  KEEP_WIDTH  input keep
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  registered ready; the delayed credit
- s_axis_tlast  in  1  input last
- s_axis_tuser  in  USER_WIDTH  input user
- m_axis_tdata  out  DATA_WIDTH  FIFO head data
- m_axis_tkeep  out  KEEP_WIDTH  FIFO head keep; all-ones when KEEP_ENABLE=0
- m_axis_tvalid  out  1  FIFO non-empty
- m_axis_tready  in  1  consumer ready
- m_axis_tlast  out  1  FIFO head last; 1 when LAST_ENABLE=0
- m_axis_tuser  out  USER_WIDTH  FIFO head user; 0 when USER_ENABLE=0

Behaviour:
- Clocking and reset:
  - All state is clocked on clk; the only reset is rst, synchronous and active-high.
  - In reset: s_axis_tready=0, m_axis_tvalid=0, FIFO count=0, all pipe valid bits=0, ready shift register=0. Data registers are not reset.
- Upstream acceptance: a beat is taken when s_axis_tvalid && s_axis_tready. The upstream source may present tvalid regardless of tready.
- Forward path:
  - The accepted beat enters LENGTH register stages. Each stage holds valid+payload and advances every cycle; there is no stall.
  - A stage-LENGTH valid writes the FIFO in that cycle.
  - Input-to-FIFO-write latency = LENGTH cycles. Input-to-m_axis_tvalid latency = LENGTH+1 cycles when the FIFO is empty.
- Ready path:
  - ready_int = (count < FIFO_DEPTH-2*LENGTH), computed from the registered count.
  - ready_int passes through a LENGTH-deep shift register; its last stage drives s_axis_tready.
- Overflow guarantee: the beats that can still arrive after any ready_int decision are bounded by 2*LENGTH+1, so a write never occurs while the FIFO is full. The FIFO needs no write-side backpressure.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than log2(FIFO_DEPTH); wrap-around is modulo FIFO_DEPTH.
  - Empty when the pointers are equal; full when they differ only in the MSB.
  - Read occurs on m_axis_tvalid && m_axis_tready.
  - Simultaneous read and write: count unchanged and both pointers advance. This also applies when the FIFO is full, where the read frees the slot in the same cycle.
  - Output registered from the FIFO: first-word-fall-through with m_axis_tvalid registered.
- Throughput: with m_axis_tready held at 1, sustained rate is 1 beat/cycle after the initial latency.
- Packet integrity: tlast, tkeep and tuser travel with their beat. Order is preserved.
- Reset mid-transfer: all in-flight and buffered beats are discarded. s_axis_tready stays 0 for LENGTH cycles after rst deasserts, then rises.
- LENGTH=0: s_axis_tready = m_axis_tready and all m_* = s_* combinationally. The FIFO is not instantiated.

Optional Feature:
- Macro: AXIS_PIPE_FIFO_RX_STATUS_EN
- When defined, two extra ports are present:
  - status_count, out, $clog2(FIFO_DEPTH)+1 bits: registered FIFO occupancy.
  - status_overflow, out, 1 bit: sticky; set if a stage-LENGTH write coincides with full and no read; cleared only by rst.
- When status_overflow sets, the offending beat is dropped.
- When not defined, neither port exists and no status logic is synthesized. Data-path behaviour is identical either way.

Test Plan:
- Reset then idle (LENGTH=2, FIFO_DEPTH=8):
  - rst for 3 cycles gives s_axis_tready=0 and m_axis_tvalid=0.
  - s_axis_tready=1 exactly 2 cycles after rst falls.
- Single beat: tdata=0xA5, tlast=1 accepted at cycle T, m_axis_tready=1.
  - m_axis_tvalid=1 with tdata=0xA5, tlast=1 at T+3 for exactly one cycle.
- Streaming: 64 consecutive beats 0x00..0x3F with m_axis_tready=1.
  - Output 0x00..0x3F in order, no gaps after the first beat, s_axis_tready never drops.
- Backpressure: m_axis_tready=0 with a continuous source.
  - FIFO fills; s_axis_tready falls once count reaches 4.
  - Count saturates at 8 or below with no loss.
  - status_overflow stays 0 (macro defined).
  - Release m_axis_tready: all beats drain in order.
- Random: random s_axis_tvalid and m_axis_tready at 50% each, 10k beats with random tlast/tuser.
  - Scoreboard exact match; count never exceeds 8.
- Mid-stream reset: rst asserted with 5 beats buffered.
  - Next cycle m_axis_tvalid=0.
  - Post-reset beat 0x11 is the first output; no stale data appears.

Source files
------------

// File: rtl/axis_pipeline_fifo_rx.sv
// axis_pipeline_fifo_rx
// Receive-end termination of a long AXI-Stream link. Accepted beats travel
// through LENGTH forward register stages. They land in a local FIFO that is
// large enough to absorb every beat still in flight. The upstream tready is
// a credit delayed through LENGTH registers, so no combinational path
// crosses the link in either direction. LENGTH=0 degenerates to a wire.
// Optional build macro: AXIS_PIPE_FIFO_RX_STATUS_EN adds status_count and
// status_overflow. With the macro undefined, no status logic exists.
module axis_pipeline_fifo_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter bit LAST_ENABLE = 1'b1,
    parameter bit USER_ENABLE = 1'b1,
    parameter int USER_WIDTH  = 1,
    parameter int LENGTH      = 2,
    parameter int FIFO_DEPTH  = 4 * LENGTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser
`ifdef AXIS_PIPE_FIFO_RX_STATUS_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0] status_count,
    output logic                        status_overflow
`endif
);

    // One packed word carries a beat and all of its sideband fields.
    localparam int PW     = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
    localparam int DEPTH  = (FIFO_DEPTH < 2) ? 2 : FIFO_DEPTH;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [KEEP_WIDTH-1:0] in_keep;
    logic                  in_last;
    logic [USER_WIDTH-1:0] in_user;
    logic [PW-1:0]         in_payload;
    logic [PW-1:0]         out_payload;
    logic                  out_valid;
    logic                  in_ready;

    // Disabled sideband fields are replaced by their fixed values at the input.
    assign in_keep    = KEEP_ENABLE ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
    assign in_last    = LAST_ENABLE ? s_axis_tlast : 1'b1;
    assign in_user    = USER_ENABLE ? s_axis_tuser : {USER_WIDTH{1'b0}};
    assign in_payload = {in_user, in_last, in_keep, s_axis_tdata};

    assign s_axis_tready = in_ready;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_payload[DATA_WIDTH-1:0];
    assign m_axis_tkeep  = out_payload[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis_tlast  = out_payload[DATA_WIDTH + KEEP_WIDTH];
    assign m_axis_tuser  = out_payload[PW-1 -: USER_WIDTH];

    genvar gi;

    if (LENGTH == 0) begin : g_bypass
        assign in_ready    = m_axis_tready;
        assign out_valid   = s_axis_tvalid;
        assign out_payload = in_payload;
`ifdef AXIS_PIPE_FIFO_RX_STATUS_EN
        assign status_count    = '0;
        assign status_overflow = 1'b0;
`endif
    end else begin : g_pipe
        localparam logic [CNT_W-1:0] READY_THRESH = CNT_W'(FIFO_DEPTH - 2 * LENGTH);

        logic          stage_valid_reg  [LENGTH];
        logic          stage_valid_next [LENGTH];
        logic [PW-1:0] stage_data_reg   [LENGTH];
        logic [PW-1:0] stage_data_next  [LENGTH];
        logic          ready_sr_reg     [LENGTH];
        logic          ready_sr_next    [LENGTH];

        logic [PW-1:0]    mem [DEPTH];
        logic [CNT_W-1:0] wr_ptr_reg;
        logic [CNT_W-1:0] rd_ptr_reg;
        logic [CNT_W-1:0] count_reg;
        logic [CNT_W-1:0] count_next;
        logic             m_valid_reg;
        logic             ready_int;
        logic             s_accept;
        logic             wr_en;
        logic             rd_en;

        assign s_accept  = s_axis_tvalid && ready_sr_reg[LENGTH-1];
        assign ready_int = (count_reg < READY_THRESH);
        assign rd_en     = m_valid_reg && m_axis_tready;

        // Stage 0 takes the accepted beat or credit. Each later stage copies its predecessor.
        for (gi = 0; gi < LENGTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_valid_next[gi] = s_accept;
                assign stage_data_next[gi]  = in_payload;
                assign ready_sr_next[gi]    = ready_int;
            end else begin : g_body
                assign stage_valid_next[gi] = stage_valid_reg[gi-1];
                assign stage_data_next[gi]  = stage_data_reg[gi-1];
                assign ready_sr_next[gi]    = ready_sr_reg[gi-1];
            end
        end

        // Forward beat pipe and reverse credit pipe advance every cycle and never stall.
        always_ff @(posedge clk) begin
            for (int i = 0; i < LENGTH; i++) begin
                stage_data_reg[i] <= stage_data_next[i];
                if (rst) begin
                    stage_valid_reg[i] <= 1'b0;
                    ready_sr_reg[i]    <= 1'b0;
                end else begin
                    stage_valid_reg[i] <= stage_valid_next[i];
                    ready_sr_reg[i]    <= ready_sr_next[i];
                end
            end
        end

`ifdef AXIS_PIPE_FIFO_RX_STATUS_EN
        logic full;
        logic overflow;
        logic overflow_reg;
        assign full     = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {ADDR_W{1'b0}}});
        assign overflow = stage_valid_reg[LENGTH-1] && full && !rd_en;
        assign wr_en    = stage_valid_reg[LENGTH-1] && !overflow;

        // Sticky overflow flag. The offending beat has already been dropped through wr_en.
        always_ff @(posedge clk) begin
            if (rst) begin
                overflow_reg <= 1'b0;
            end else if (overflow) begin
                overflow_reg <= 1'b1;
            end
        end

        assign status_count    = count_reg;
        assign status_overflow = overflow_reg;
`else
        // The credit loop bounds in-flight beats, so a write can never hit a full FIFO.
        assign wr_en = stage_valid_reg[LENGTH-1];
`endif

        // Occupancy is unchanged when a write and a read happen in the same cycle.
        always_comb begin
            count_next = count_reg;
            case ({wr_en, rd_en})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end

        // Pointer, occupancy and registered output-valid bookkeeping.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_reg  <= '0;
                rd_ptr_reg  <= '0;
                count_reg   <= '0;
                m_valid_reg <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_reg <= wr_ptr_reg + CNT_W'(1);
                end
                if (rd_en) begin
                    rd_ptr_reg <= rd_ptr_reg + CNT_W'(1);
                end
                count_reg   <= count_next;
                m_valid_reg <= (count_next != '0);
            end
        end

        // The storage array is written from the last forward stage.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_ptr_reg[ADDR_W-1:0]] <= stage_data_reg[LENGTH-1];
            end
        end

        // First-word-fall-through: the head entry is always presented.
        assign out_payload = mem[rd_ptr_reg[ADDR_W-1:0]];
        assign out_valid   = m_valid_reg;
        assign in_ready    = ready_sr_reg[LENGTH-1];
    end

endmodule

// File: tb/tb_axis_pipeline_fifo_rx.sv
// Bench for axis_pipeline_fifo_rx (LENGTH=2, FIFO_DEPTH=8, 8-bit data).
// The reference model counts handshakes per cycle. From those counts it derives
// the FIFO occupancy, the expected m_axis_tvalid and the expected delayed
// s_axis_tready. A queue scoreboard checks payload order and content.
module tb_axis_pipeline_fifo_rx;

    localparam int DW    = 8;
    localparam int KW    = 1;
    localparam int UW    = 1;
    localparam int LEN   = 2;
    localparam int DEPTH = 8;
    localparam int HIST  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [UW-1:0] s_axis_tuser;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [UW-1:0] m_axis_tuser;
`ifdef AXIS_PIPE_FIFO_RX_STATUS_EN
    logic [$clog2(DEPTH):0] status_count;
    logic                   status_overflow;
`endif

    always #5 clk = ~clk;

    axis_pipeline_fifo_rx #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .LENGTH     (LEN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
`ifdef AXIS_PIPE_FIFO_RX_STATUS_EN
        ,
        .status_count    (status_count),
        .status_overflow (status_overflow)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t sb_q[$];
    int    acc_hist [HIST];
    int    rd_hist  [HIST];
    int    acc_cum  = 0;
    int    rd_cum   = 0;
    int    cyc      = 0;
    int    gcyc     = 0;
    bit    s_hs     = 1'b0;
    bit    m_hs     = 1'b0;
    bit    verbose  = 1'b1;
    int    phase_acc;
    int    phase_out;
    int    last_acc_cyc;
    int    first_out_cyc;
    int    last_out_cyc;
    logic [DW-1:0] first_out_data;
    logic [DW-1:0] seq_data;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int acc_at(input int idx);
        return (idx < 0) ? 0 : acc_hist[idx % HIST];
    endfunction

    function automatic int rd_at(input int idx);
        return (idx < 0) ? 0 : rd_hist[idx % HIST];
    endfunction

    // One clock cycle: check outputs at the negative edge, update the model, then step past the rising edge.
    task automatic cycle();
        int    cnt_now;
        int    cnt_lag;
        bit    exp_rdy;
        beat_t exp_b;
        @(negedge clk);
        // A beat accepted in cycle a is written at the end of cycle a+LEN.
        cnt_now = acc_at(cyc - LEN - 1) - rd_at(cyc - 1);
        cnt_lag = acc_at(cyc - 2 * LEN - 1) - rd_at(cyc - LEN - 1);
        exp_rdy = (cyc >= LEN) && (cnt_lag < DEPTH - 2 * LEN);
        check_val("s_tready", s_axis_tready, exp_rdy);
        check_val("m_tvalid", m_axis_tvalid, cnt_now > 0);
`ifdef AXIS_PIPE_FIFO_RX_STATUS_EN
        check_val("status_count", status_count, cnt_now);
        check_val("status_overflow", status_overflow, 0);
`endif
        s_hs = s_axis_tvalid && s_axis_tready;
        m_hs = m_axis_tvalid && m_axis_tready;
        if (s_hs) begin
            sb_q.push_back('{data: s_axis_tdata, last: s_axis_tlast, user: s_axis_tuser});
            phase_acc++;
            last_acc_cyc = gcyc;
        end
        if (m_hs) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_beat", {1'b1, m_axis_tdata}, {1'b0, m_axis_tdata});
            end else begin
                exp_b = sb_q.pop_front();
                check_val("m_tdata", m_axis_tdata, exp_b.data);
                check_val("m_tlast", m_axis_tlast, exp_b.last);
                check_val("m_tuser", m_axis_tuser, exp_b.user);
                check_val("m_tkeep", m_axis_tkeep, 1);
            end
            if (phase_out == 0) begin
                first_out_cyc  = gcyc;
                first_out_data = m_axis_tdata;
            end
            last_out_cyc = gcyc;
            phase_out++;
            if (verbose) begin
                $display("[%0t] out beat data=0x%02h last=%0b user=%0b", $time,
                         m_axis_tdata, m_axis_tlast, m_axis_tuser);
            end
        end
        if (rst) begin
            sb_q.delete();
            acc_cum = 0;
            rd_cum  = 0;
            cyc     = 0;
        end else begin
            acc_cum += int'(s_hs);
            rd_cum  += int'(m_hs);
            acc_hist[cyc % HIST] = acc_cum;
            rd_hist[cyc % HIST]  = rd_cum;
            cyc++;
        end
        gcyc++;
        @(posedge clk);
        #1;
    endtask

    // Source: hold a pending beat until it is taken, otherwise optionally offer a new one.
    task automatic src_step(input bit offer, input bit rand_data);
        if (s_axis_tvalid && !s_hs) begin
            return;
        end
        s_axis_tvalid = offer;
        if (offer) begin
            if (rand_data) begin
                s_axis_tdata = DW'($urandom);
                s_axis_tlast = 1'($urandom);
                s_axis_tuser = UW'($urandom);
            end else begin
                s_axis_tdata = seq_data;
                s_axis_tlast = (seq_data[2:0] == 3'd7);
                s_axis_tuser = seq_data[0];
                seq_data     = seq_data + 1'b1;
            end
            s_axis_tkeep = KW'($urandom);
        end
    endtask

    task automatic new_phase();
        phase_acc = 0;
        phase_out = 0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        m_axis_tready = 1'b1;
        while ((sb_q.size() != 0 || s_axis_tvalid) && n < 200) begin
            src_step(1'b0, 1'b0);
            cycle();
            n++;
        end
        check_val(tag, sb_q.size(), 0);
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b0;
        seq_data      = '0;
        new_phase();
        @(posedge clk);
        #1;

        // Reset, then idle: the model expects tready to rise exactly LEN cycles after rst falls.
        repeat (3) cycle();
        rst = 1'b0;
        repeat (4) cycle();
        check_val("idle_tready", s_axis_tready, 1);

        // Single beat: the latency from acceptance to output is LEN+1 cycles.
        new_phase();
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'hA5;
        s_axis_tlast  = 1'b1;
        s_axis_tuser  = 1'b0;
        cycle();
        s_axis_tvalid = 1'b0;
        n = 0;
        while (phase_out == 0 && n < 20) begin
            cycle();
            n++;
        end
        check_val("single_seen", phase_out, 1);
        check_val("single_latency", first_out_cyc - last_acc_cyc, LEN + 1);
        check_val("single_data", first_out_data, 8'hA5);
        repeat (3) cycle();

        // Streaming: 64 back-to-back beats with no gaps at either side.
        new_phase();
        seq_data = '0;
        n = 0;
        while (phase_acc < 64 && n < 200) begin
            src_step(1'b1, 1'b0);
            cycle();
            n++;
        end
        check_val("stream_in_cycles", n, 64);
        drain("stream_drain");
        check_val("stream_out_count", phase_out, 64);
        check_val("stream_out_span", last_out_cyc - first_out_cyc, 63);

        // Backpressure: a stalled sink with a continuous source must fill the FIFO without loss.
        new_phase();
        verbose       = 1'b0;
        m_axis_tready = 1'b0;
        repeat (30) begin
            src_step(1'b1, 1'b0);
            cycle();
        end
        check_val("bp_no_output", phase_out, 0);
        check_val("bp_tready_low", s_axis_tready, 0);
        verbose = 1'b1;
        drain("bp_drain");
        check_val("bp_all_out", phase_out, phase_acc);

        // Random traffic: 50% source valid, 50% sink ready.
        new_phase();
        verbose = 1'b0;
        n = 0;
        while (phase_acc < 10000 && n < 60000) begin
            m_axis_tready = 1'($urandom);
            src_step(1'($urandom), 1'b1);
            cycle();
            n++;
        end
        check_val("rand_accepted", phase_acc, 10000);
        drain("rand_drain");
        check_val("rand_all_out", phase_out, phase_acc);
        verbose = 1'b1;

        // Mid-stream reset with five buffered beats; nothing stale may come out afterwards.
        new_phase();
        m_axis_tready = 1'b0;
        n = 0;
        while (phase_acc < 5 && n < 50) begin
            src_step(1'b1, 1'b0);
            cycle();
            n++;
        end
        src_step(1'b0, 1'b0);
        repeat (LEN + 2) cycle();
        check_val("mid_buffered_valid", m_axis_tvalid, 1);
        rst = 1'b1;
        cycle();
        check_val("mid_rst_valid", m_axis_tvalid, 0);
        cycle();
        rst = 1'b0;
        new_phase();
        m_axis_tready = 1'b1;
        n = 0;
        while (!s_axis_tready && n < 20) begin
            cycle();
            n++;
        end
        check_val("mid_tready_delay", n, LEN);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h11;
        s_axis_tlast  = 1'b1;
        s_axis_tuser  = 1'b1;
        cycle();
        s_axis_tvalid = 1'b0;
        repeat (LEN + 4) cycle();
        check_val("mid_first_data", first_out_data, 8'h11);
        check_val("mid_out_count", phase_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
